// File: rtl/turn_signal_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : turn_signal_seq_pkg
//  Description : Shared definitions for the turn-signal / hazard controller.
//                The package holds the 2-bit mode encodings, the mode enum
//                built from them, and the request-priority decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package turn_signal_seq_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_LEFT  = 2'd1;
    localparam logic [1:0] MODE_RIGHT = 2'd2;
    localparam logic [1:0] MODE_HAZ   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = MODE_IDLE,
        ST_LEFT  = MODE_LEFT,
        ST_RIGHT = MODE_RIGHT,
        ST_HAZ   = MODE_HAZ
    } mode_e;

    // Asking for both directions at once is treated as a hazard request.
    function automatic mode_e decode_req(input logic haz, input logic left,
                                         input logic right);
        if (haz || (left && right)) return ST_HAZ;
        else if (left)              return ST_LEFT;
        else if (right)             return ST_RIGHT;
        else                        return ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turn_signal_seq_sevenseg.sv
`default_nettype none
// ============================================================================
//  Module      : sevenSeg
//  Description : Hex digit to 7-segment decoder for a common-anode display.
//                Segments are active low, bit order {dp,g,f,e,d,c,b,a};
//                the decimal point is always off.
//  Ports       : val  in  4  digit value 0..F
//                seg  out 8  segment pattern
//  Revision    : 1.0  initial release
// ============================================================================
module sevenSeg (
    input  logic [3:0] val,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (val)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/turn_signal_seq.sv
`default_nettype none
// ============================================================================
//  Module      : turn_signal_seq
//  Description : Sequential turn-signal / hazard controller. A free-running
//                divider produces a one-cycle step tick; on each tick the
//                mode/step state advances and the lamp registers are reloaded.
//                The current step is shown on one 7-segment digit.
//  Ports       : clock       in   1     board clock, rising edge
//                reset_n     in   1     asynchronous active-low reset
//                left_req    in   1     left sweep request (level)
//                right_req   in   1     right sweep request (level)
//                hazard_req  in   1     hazard flash request (level)
//                left_leds   out  LEDS  left lamps, bit 0 innermost
//                right_leds  out  LEDS  right lamps, bit 0 innermost
//                mode        out  2     0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ
//                step        out  SW    current sequence step
//                hex         out  8     7-segment pattern of step
//  Revision    : 1.0  initial release
// ============================================================================
module turn_signal_seq
    import turn_signal_seq_pkg::*;
#(
    parameter  int LEDS     = 3,
    parameter  int TICK_DIV = 25_000_000,
    localparam int SW       = $clog2(LEDS + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            left_req,
    input  logic            right_req,
    input  logic            hazard_req,
    output logic [LEDS-1:0] left_leds,
    output logic [LEDS-1:0] right_leds,
    output logic [1:0]      mode,
    output logic [SW-1:0]   step,
    output logic [7:0]      hex
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_DIV_MAX = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] C_LAST    = SW'(LEDS);
    localparam logic [SW-1:0] C_ONE     = SW'(1);

    // lamps[i] = (i < n)
    function automatic logic [LEDS-1:0] therm(input logic [SW-1:0] n);
        logic [LEDS-1:0] t;
        t = '0;
        for (int i = 0; i < LEDS; i++) begin
            t[i] = (i < int'(n));
        end
        return t;
    endfunction

    logic [CW-1:0]   cnt_q;
    logic            w_tick;
    mode_e           w_req;
    mode_e           mode_q, mode_d;
    logic [SW-1:0]   step_q, step_d;
    logic [LEDS-1:0] left_q, left_d;
    logic [LEDS-1:0] right_q, right_d;
    logic [3:0]      w_hex_val;

    assign w_tick = (cnt_q == C_DIV_MAX);
    assign w_req  = decode_req(hazard_req, left_req, right_req);

    always_comb begin
        mode_d  = mode_q;
        step_d  = step_q;
        left_d  = '0;
        right_d = '0;

        if (w_tick) begin
            case (mode_q)
                ST_IDLE: begin
                    if (w_req != ST_IDLE) begin
                        mode_d = w_req;
                        step_d = C_ONE;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    // Only a hazard request may interrupt a running sweep;
                    // everything else is taken at the step-0 boundary.
                    if (w_req == ST_HAZ) begin
                        mode_d = ST_HAZ;
                        step_d = C_ONE;
                    end else if (step_q == '0) begin
                        mode_d = w_req;
                        step_d = (w_req == ST_IDLE) ? '0 : C_ONE;
                    end else if (step_q == C_LAST) begin
                        step_d = '0;
                    end else begin
                        step_d = step_q + C_ONE;
                    end
                end
                ST_HAZ: begin
                    if (step_q != '0) begin
                        step_d = '0;
                    end else begin
                        mode_d = w_req;
                        step_d = (w_req == ST_IDLE) ? '0 : C_ONE;
                    end
                end
                default: begin
                    mode_d = ST_IDLE;
                    step_d = '0;
                end
            endcase
        end

        // Lamps follow the next state so they change in the same clock as
        // mode and step.
        case (mode_d)
            ST_LEFT:  left_d  = therm(step_d);
            ST_RIGHT: right_d = therm(step_d);
            ST_HAZ: begin
                left_d  = (step_d != '0) ? '1 : '0;
                right_d = (step_d != '0) ? '1 : '0;
            end
            default: begin
                left_d  = '0;
                right_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            mode_q  <= ST_IDLE;
            step_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            cnt_q   <= w_tick ? '0 : cnt_q + CW'(1);
            mode_q  <= mode_d;
            step_q  <= step_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign left_leds  = left_q;
    assign right_leds = right_q;
    assign mode       = mode_q;
    assign step       = step_q;
    assign w_hex_val  = 4'(step_q);

    sevenSeg H0 (
        .val (w_hex_val),
        .seg (hex)
    );

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turn_signal_seq
//  Description : Self-checking bench for turn_signal_seq (LEDS=3, TICK_DIV=4).
//                A cycle-level reference model follows the sequencing rules
//                using plain integers; every output is compared each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_turn_signal_seq;

    localparam int LEDS = 3;
    localparam int TD   = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       left_req = 1'b0;
    logic       right_req = 1'b0;
    logic       hazard_req = 1'b0;
    logic [2:0] left_leds;
    logic [2:0] right_leds;
    logic [1:0] mode;
    logic [1:0] step;
    logic [7:0] hex;

    int tests = 0;
    int fails = 0;

    int m_div, m_mode, m_step;
    logic [7:0] seg_tab [0:3];

    turn_signal_seq #(.LEDS(LEDS), .TICK_DIV(TD)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .left_req   (left_req),
        .right_req  (right_req),
        .hazard_req (hazard_req),
        .left_leds  (left_leds),
        .right_leds (right_leds),
        .mode       (mode),
        .step       (step),
        .hex        (hex)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div  = 0;
        m_mode = 0;
        m_step = 0;
    endtask

    function automatic int decode(input logic h, input logic l, input logic r);
        if (h || (l && r)) return 3;
        if (l) return 1;
        if (r) return 2;
        return 0;
    endfunction

    // One board clock of the reference behaviour.
    task automatic model_clock();
        int d;
        bit tick;
        tick  = (m_div == TD - 1);
        m_div = (m_div + 1) % TD;
        if (!tick) return;
        d = decode(hazard_req, left_req, right_req);
        if (m_mode == 0) begin
            if (d != 0) begin m_mode = d; m_step = 1; end
        end else if (m_mode == 3) begin
            if (m_step == 1) m_step = 0;
            else begin m_mode = d; m_step = (d != 0) ? 1 : 0; end
        end else begin
            if (d == 3)               begin m_mode = 3; m_step = 1; end
            else if (m_step == 0)     begin m_mode = d; m_step = (d != 0) ? 1 : 0; end
            else if (m_step == LEDS)  m_step = 0;
            else                      m_step = m_step + 1;
        end
    endtask

    task automatic check_all();
        int bar, exp_l, exp_r;
        bar   = (1 << m_step) - 1;
        exp_l = (m_mode == 1) ? bar : (m_mode == 3 && m_step == 1) ? 7 : 0;
        exp_r = (m_mode == 2) ? bar : (m_mode == 3 && m_step == 1) ? 7 : 0;
        chk("left_leds",  32'(left_leds),  32'(exp_l));
        chk("right_leds", 32'(right_leds), 32'(exp_r));
        chk("mode",       32'(mode),       32'(m_mode));
        chk("step",       32'(step),       32'(m_step));
        chk("hex",        32'(hex),        32'(seg_tab[m_step]));
    endtask

    task automatic clk_step();
        @(posedge clock);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    task automatic wait_state(input string tag, input int md, input int st);
        int k;
        k = 0;
        while (!(m_mode == md && m_step == st) && k < 64) begin
            clk_step();
            k++;
        end
        chk(tag, 32'(k < 64), 32'd1);
    endtask

    initial begin
        seg_tab[0] = 8'hC0;
        seg_tab[1] = 8'hF9;
        seg_tab[2] = 8'hA4;
        seg_tab[3] = 8'hB0;
        model_reset();

        // Reset state
        #12;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
        run(6);

        // Left held: 001,011,111,000,001,...; right stays dark
        left_req = 1'b1;
        run(24);

        // Asynchronous reset in the middle of a sweep
        wait_state("wait_left_s2", 1, 2);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
        run(12);
        left_req = 1'b0;
        run(20);

        // Right for a single tick: full sweep then IDLE
        right_req = 1'b1;
        wait_state("wait_right_s1", 2, 1);
        right_req = 1'b0;
        run(24);

        // Hazard pre-empts a left sweep at step 2
        left_req = 1'b1;
        wait_state("wait_left_s2b", 1, 2);
        hazard_req = 1'b1;
        wait_state("wait_haz", 3, 1);
        hazard_req = 1'b0;
        left_req   = 1'b0;
        run(20);

        // Left then right at step 1: left completes before right starts
        left_req = 1'b1;
        wait_state("wait_left_s1", 1, 1);
        left_req  = 1'b0;
        right_req = 1'b1;
        run(28);
        right_req = 1'b0;
        run(24);

        // Both directions from IDLE flash hazard
        left_req  = 1'b1;
        right_req = 1'b1;
        run(24);
        left_req  = 1'b0;
        right_req = 1'b0;
        run(12);

        // Randomised request traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) left_req   = 1'($urandom);
            if ($urandom_range(0, 7) == 0) right_req  = 1'($urandom);
            if ($urandom_range(0, 15) == 0) hazard_req = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
                check_all();
                @(negedge clock);
                reset_n = 1'b1;
            end
            clk_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
